// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
package timer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a base tick: ce is high for one cycle every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50_000,
    parameter int unsigned PRE_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic ce
);

    localparam logic [PRE_W-1:0] LastVal = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_cnt;

    assign ce = en && (r_cnt == LastVal);

    // Prescaler count: clear has priority, otherwise wrap at PRESCALE-1 while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == LastVal) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: prescaled base tick, periodic/one-shot down-counter,
// expiry pulse, square wave and remaining-count readout.
module interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 50_000,
    parameter int unsigned PRE_W    = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    output logic             tick_o,
    output logic             wave_o,
    output logic [CNT_W-1:0] count_o,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_tick;
    logic             r_wave;
    logic             r_mode;
    logic [CNT_W-1:0] r_count;

    logic w_run;
    logic w_ce;
    logic w_start_ok;
    logic w_clr;
    logic w_expire;

    assign w_run      = (r_state == StRun);
    // A start with a zero period is ignored outright.
    assign w_start_ok = start && (period != '0);
    assign w_clr      = stop || w_start_ok;
    assign w_expire   = w_ce && (r_count == CntOne);

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_run),
        .ce    (w_ce)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: stop beats start beats expiry.
    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = StIdle;
        end else if (w_start_ok) begin
            w_state_next = StRun;
        end else if (w_expire && (r_mode == MODE_ONESHOT)) begin
            w_state_next = StDone;
        end
    end

    // Interval counter, latched mode, expiry pulse and square wave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick  <= 1'b0;
            r_wave  <= 1'b0;
            r_mode  <= MODE_PERIODIC;
            r_count <= '0;
        end else begin
            r_tick <= 1'b0;
            if (stop) begin
                // Halt: count and wave hold their values.
            end else if (w_start_ok) begin
                r_count <= period;
                r_mode  <= mode;
            end else if (w_ce) begin
                if (w_expire) begin
                    r_tick <= 1'b1;
                    r_wave <= ~r_wave;
                    if (r_mode == MODE_ONESHOT) begin
                        r_count <= '0;
                    end else if (period != '0) begin
                        r_count <= period;
                    end
                end else if (r_count > CntOne) begin
                    r_count <= r_count - CntOne;
                end
            end
        end
    end

    assign tick_o  = r_tick;
    assign wave_o  = r_wave;
    assign count_o = r_count;
    assign busy    = w_run;
    assign done    = (r_state == StDone);

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer (PRESCALE=4, CNT_W=8).
module tb_interval_timer;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PRE_W    = 4;
    localparam int unsigned CNT_W    = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] period;
    logic             tick_o;
    logic             wave_o;
    logic [CNT_W-1:0] count_o;
    logic             busy;
    logic             done;

    int n_pass;
    int n_total;
    int ticks;

    interval_timer #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .tick_o  (tick_o),
        .wave_o  (wave_o),
        .count_o (count_o),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n edges, leaving time 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (E0); returns 1 ns after E0.
    task automatic pulse_start(input logic [CNT_W-1:0] p, input logic m);
        period = p;
        mode   = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Count tick pulses over n edges.
    task automatic count_ticks(input int n, output int t);
        t = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (tick_o) t++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        period  = '0;

        // Reset state
        #12;
        check("rst_tick", tick_o, 0);
        check("rst_wave", wave_o, 0);
        check("rst_count", count_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        step(2);

        // Periodic, period=3
        pulse_start(8'd3, 1'b0);
        check("per_count_e0", count_o, 3);
        check("per_busy", busy, 1);
        step(4);
        check("per_count_e4", count_o, 2);
        step(4);
        check("per_count_e8", count_o, 1);
        step(3);
        check("per_notick_e11", tick_o, 0);
        step(1);
        check("per_tick_e12", tick_o, 1);
        check("per_wave_e12", wave_o, 1);
        check("per_count_e12", count_o, 3);
        step(1);
        check("per_tick_width", tick_o, 0);
        step(10);
        check("per_notick_e23", tick_o, 0);
        step(1);
        check("per_tick_e24", tick_o, 1);
        check("per_wave_e24", wave_o, 0);
        step(12);
        check("per_tick_e36", tick_o, 1);
        check("per_wave_e36", wave_o, 1);
        pulse_stop();
        check("per_stop_busy", busy, 0);

        // One-shot, period=2
        pulse_start(8'd2, 1'b1);
        check("os_busy", busy, 1);
        step(7);
        check("os_notick_e7", tick_o, 0);
        step(1);
        check("os_tick_e8", tick_o, 1);
        check("os_done", done, 1);
        check("os_busy_off", busy, 0);
        check("os_count0", count_o, 0);
        check("os_wave", wave_o, 0);
        count_ticks(32, ticks);
        check("os_no_more_ticks", ticks, 0);
        check("os_done_held", done, 1);
        pulse_start(8'd2, 1'b1);
        check("os_restart_done", done, 0);
        check("os_restart_busy", busy, 1);
        pulse_stop();

        // Stop at E0+6, period=3
        pulse_start(8'd3, 1'b0);
        step(5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_count", count_o, 2);
        check("stop_wave", wave_o, 0);
        count_ticks(34, ticks);
        check("stop_no_ticks", ticks, 0);
        check("stop_count_hold", count_o, 2);
        pulse_start(8'd3, 1'b0);
        step(11);
        check("restart_notick", tick_o, 0);
        step(1);
        check("restart_tick", tick_o, 1);
        check("restart_wave", wave_o, 1);
        pulse_stop();

        // Corner: start with period=0
        pulse_start(8'd0, 1'b0);
        check("p0_busy", busy, 0);
        check("p0_count", count_o, 3);

        // Corner: start and stop together
        period = 8'd4;
        start  = 1'b1;
        stop   = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 0);
        check("startstop_count", count_o, 3);

        // Corner: restart on expiry edge
        pulse_start(8'd3, 1'b0);
        step(11);
        pulse_start(8'd3, 1'b0);
        check("rs_notick", tick_o, 0);
        check("rs_wave", wave_o, 1);
        check("rs_count", count_o, 3);
        step(11);
        check("rs_notick_e23", tick_o, 0);
        step(1);
        check("rs_tick_e24", tick_o, 1);
        check("rs_wave_e24", wave_o, 0);

        // Async reset mid-cycle
        pulse_start(8'd3, 1'b0);
        step(4);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_count", count_o, 0);
        check("arst_tick", tick_o, 0);
        check("arst_wave", wave_o, 0);
        #2;
        rst_n = 1'b1;
        count_ticks(20, ticks);
        check("arst_no_ticks", ticks, 0);
        check("arst_idle", busy, 0);

        // Period changed 3->5 mid-interval
        pulse_start(8'd3, 1'b0);
        step(1);
        period = 8'd5;
        step(10);
        check("pc_notick_e11", tick_o, 0);
        step(1);
        check("pc_tick_e12", tick_o, 1);
        check("pc_count_e12", count_o, 5);
        step(19);
        check("pc_notick_e31", tick_o, 0);
        step(1);
        check("pc_tick_e32", tick_o, 1);
        step(20);
        check("pc_tick_e52", tick_o, 1);
        check("pc_wave_e52", wave_o, 1);
        pulse_stop();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
Programmable interval timer; the parametrised successor to the fixed 1 s toggle counter.
- A prescaler divides clk into a base tick; a down-counter counts PERIOD base ticks per interval.
- Supports periodic and one-shot modes, start/stop control, a 1-cycle expiry pulse, a toggling square wave, a remaining-count readout and a done flag.
- Serves as the shared timebase for display refresh, debounce and stopwatch blocks.

Parameters:
PRESCALE, 50_000, clk cycles per base tick (1 ms at 50 MHz); legal range >= 1
PRE_W, 16, prescaler counter width; must hold PRESCALE-1
CNT_W, 16, interval counter width

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
start  input  1  1-cycle request: load period and run
stop  input  1  1-cycle request: halt, return to IDLE
mode  input  1  0 = periodic, 1 = one-shot; sampled with start
period  input  CNT_W  interval length in base ticks; sampled at start and at each periodic reload
tick_o  output  1  registered 1-cycle pulse at each expiry
wave_o  output  1  toggles at each expiry (50% duty in periodic mode)
count_o  output  CNT_W  remaining base ticks in the current interval
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot finished)

Behaviour:
- Reset (async, rst_n=0): state IDLE; prescaler 0; tick_o, wave_o, count_o, busy and done all 0; mode register 0.
- States:
  - IDLE: start with period!=0 -> RUN.
  - RUN: expiry in one-shot mode -> DONE; stop -> IDLE.
  - DONE: start with period!=0 -> RUN; stop -> IDLE.
- Start accepted at edge E0:
  - count_o <= period; prescaler <= 0; mode latched; done <= 0.
  - busy is high from E0.
- Prescaler:
  - Increments only in RUN; wraps PRESCALE-1 -> 0.
  - ce = RUN && prescaler == PRESCALE-1 (combinational). PRESCALE = 1 gives ce every RUN cycle.
- On ce:
  - count_o > 1: decrement.
  - count_o == 1: expiry.
- Expiry:
  - tick_o <= 1 for exactly one cycle; wave_o toggles.
  - Periodic: count_o <= current period input; a period value of 0 at reload holds the old value and the timer continues.
  - One-shot: count_o <= 0, busy <= 0, done <= 1.
- Latency: the first expiry register update occurs at edge E0 + period*PRESCALE. Subsequent periodic expiries follow every period*PRESCALE cycles.
- Priority, highest first: stop > start > expiry.
  - stop and start in the same cycle -> IDLE.
  - start in RUN -> restart: reload, prescaler cleared, no tick that cycle, wave_o unchanged.
  - stop on an expiry cycle -> no tick, no wave toggle.
- Stop:
  - state IDLE, prescaler 0, busy 0, done 0.
  - count_o and wave_o hold their values.
- start with period==0: ignored; state and outputs unchanged.
- period changes mid-interval: no effect until the next reload or start.
- Counter widths: no overflow is possible (down-count only). Prescaler compare uses PRE_W bits.

Decomposition:
- Package timer_pkg holds:
  - state typedef (IDLE, RUN, DONE)
  - mode constants MODE_PERIODIC = 0, MODE_ONESHOT = 1
- Sub-module tick_prescaler (parameters PRESCALE, PRE_W):
  - Ports: clk, rst_n, clr, en -> ce.
  - Clears on clr and counts while en.
- The top level holds the FSM, interval counter and output registers.

Test Plan:
(Bench uses PRESCALE=4, CNT_W=8; E0 = edge where start is sampled.)
- Periodic, period=3: tick_o high after edges E0+12, +24, +36; wave_o 0->1->0->1; count_o reads 3,2,1,3 at E0, +4, +8, +12.
- One-shot, period=2: single tick after E0+8; then done=1, busy=0, count_o=0; no tick through E0+40; a new start clears done.
- Stop sampled at E0+6 (period=3): no tick through E0+40; busy=0, count_o holds 2, wave_o unchanged. Restart gives first tick at 12 cycles after the new start.
- Corner controls:
  - start with period=0 -> busy stays 0.
  - start and stop asserted together -> IDLE.
  - start at E0+12 (expiry edge) -> no tick; next tick at E0+24.
- Async reset asserted mid-cycle at E0+5 -> all outputs 0 immediately, without waiting for a clock edge; after release, no activity until start.
- Period changed 3->5 at E0+2 (periodic): first tick at E0+12, next at E0+32, then every 20 cycles.
